obj_collision_detect: RTL and testbench
=======================================

# obj_collision_detect

Pixel-accurate collision detector that reads back the same scan the action layer renderer draws. It runs on the video clock alongside the renderer, sees the same `active`/`active_h`/`active_v` stream and object table, and recomputes per-pixel object coverage from the `obj_pkg` sprite bitmaps. Object/object and object/frame-border overlaps are accumulated over a frame, then handed to game logic once per frame through a valid/ack handshake.

## Interface
- `NUM_OBJ`, default `obj_pkg::NUM_OBJ`: number of objects; `NUM_PAIRS = NUM_OBJ*(NUM_OBJ-1)/2`.
- `ACTIVE_PELS`, default `vga_hd_pkg::ActivePels`: active pixels per line.
- `ACTIVE_LINES`, default `vga_hd_pkg::ActiveLines`: active lines per frame.

Ports:
- `vid_clk` in 1: video clock. One clock only; everything is synchronous to it.
- `vid_reset_n` in 1: reset, synchronous, active-low.
- `active` in 1: pixel valid.
- `active_h` in 12: pixel column.
- `active_v` in 12: pixel row.
- `frame_widths` in 4x8: border widths `{bottom, top, right, left}`; index 0 is left.
- `obj_x`, `obj_y` in NUM_OBJ x 12: object top-left position.
- `obj_en` in NUM_OBJ: object enable.
- `coll_pair` out NUM_PAIRS: object/object overlap flags for the reported frame.
- `coll_frame` out NUM_OBJ: object/border overlap flags.
- `coll_valid` out 1: a report is pending.
- `coll_overrun` out 1: at least one unacknowledged report was overwritten.
- `coll_frame_cnt` out 8: count of frames reported.
- `coll_ack` in 1: consumer acknowledge.

## Operation
**Coverage, per pixel with `active=1`:**
- Compute `rel_x = active_h - obj_x[i]` and `rel_y = active_v - obj_y[i]`, unsigned 12-bit with wrap. A negative offset wraps to a large value and fails the size test, so no signed compare is needed.
- `cov[i] = obj_en[i] && rel_x < ObjSizeX[i] && rel_y < ObjSizeY[i] && Obj[i][rel_y][rel_x]`.
- `border = 1` when any of these holds:
  - `active_h < frame_widths[0]`
  - `active_h > ACTIVE_PELS - frame_widths[1] - 1`
  - `active_v < frame_widths[2]`
  - `active_v > ACTIVE_LINES - frame_widths[3] - 1`
- When `active=0`, both `cov` and `border` are forced to 0.

**Pair ordering:**
- Bit k of `coll_pair` maps to pairs in lexical order (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1).
- For N=4: bit0=(0,1), bit1=(0,2), bit2=(0,3), bit3=(1,2), bit4=(1,3), bit5=(2,3).

**Accumulation:**
- The pair accumulator for (i,j) ORs in `cov[i]&cov[j]` each pixel.
- The border accumulator for object i ORs in `cov[i]&border`.
- Object positions are used live. The consumer holds them stable during active video.

**Frame end and latching:**
- Frame end is the pixel with `active=1`, `active_h=ACTIVE_PELS-1`, `active_v=ACTIVE_LINES-1`.
- At frame end the accumulators, including that pixel, are copied to `coll_pair`/`coll_frame`.
- On the same edge the accumulators clear, `coll_frame_cnt` increments (wrapping 255 to 0), and the report state machine advances.

**Report state machine** (`coll_valid`/`coll_overrun` decode the state):
- **EMPTY** (valid=0, overrun=0):
  - frame end → FULL.
  - `coll_ack` is ignored.
- **FULL** (valid=1, overrun=0):
  - `coll_ack` with no frame end → EMPTY.
  - frame end and ack on the same cycle → FULL, loaded with the new data.
  - frame end without ack → OVERRUN, new data overwrites.
- **OVERRUN** (valid=1, overrun=1):
  - ack → EMPTY (or FULL if a frame end coincides).
  - frame end without ack → stays OVERRUN, data overwritten.

**Reset:**
- All outputs, accumulators and pipeline registers go to 0; state goes to EMPTY.
- Reset mid-frame discards partial data. The first report after reset covers only pixels seen after `vid_reset_n` is released.

## Timing
- Stage 1: register `cov`, `border` and a last-pixel flag, one cycle after the input pixel.
- Stage 2: accumulate and latch.
- `coll_valid` rises, and outputs update, 2 clocks after the frame-end pixel is presented.
- Effect of `coll_ack`, sampled at an edge while valid:
  - `coll_valid` drops at that same edge, visible the next cycle.
  - `coll_overrun` drops at that same edge.
- Report data holds stable from valid rise until the next frame-end latch.
- Throughput: one pixel per clock, no stalls. `coll_ack` never backpressures the pixel stream.

## Test plan
Bench-local `obj_pkg`: NUM_OBJ=4, all sprites 16x16 fully opaque; frame 1280x720.

1. **Overlap:** obj0 at (100,100), obj1 at (110,105), all enabled, frame_widths=0 → after frame, `coll_pair=6'b000001`, `coll_frame=0`, `coll_valid=1` exactly 2 clocks after pixel (1279,719).
2. **Touching but not overlapping:** obj0 at (100,100), obj1 at (116,100) → `coll_pair=0`. Disabling obj1 while overlapping also gives `coll_pair=0`.
3. **Border hit:** frame_widths left=8, obj2 at (0,300) → `coll_frame=4'b0100`. With obj2 at (8,300) → `coll_frame=0`.
4. **Negative-offset wrap:** obj3 at (1275,715) → only 5x5 pixels are visible, and no hit is reported at (0,0)..(10,10) from wrap.
5. **Handshake:**
   - Three frames with no ack → `coll_overrun=1`, `coll_frame_cnt=3`.
   - Ack → valid=0 and overrun=0 the next cycle.
   - Ack on the same cycle as a frame end → valid stays 1, overrun=0.
6. **Reset mid-frame:** assert `vid_reset_n=0` at line 360 with obj0/obj1 overlapping at line 100 → all outputs 0. The next report shows `coll_pair=0`, `coll_frame_cnt=1`.

Source files
------------

// File: rtl/obj_collision_detect_if.sv
// obj_collision_detect_if
//   Bundles the pixel stream, object table and per-frame collision report
//   of obj_collision_detect.
//   master : pixel source / game logic (drives pixels, objects, coll_ack)
//   slave  : the detector (drives coll_* report signals)
//   Ports of interest:
//     active, active_h, active_v     pixel stream
//     frame_widths                   border widths {bottom, top, right, left}
//     obj_x, obj_y, obj_en           object table
//     coll_pair, coll_frame          report data
//     coll_valid, coll_overrun       report state
//     coll_frame_cnt                 frames reported
//     coll_ack                       consumer acknowledge
interface obj_collision_detect_if #(
    parameter int NUM_OBJ = 4
);
    localparam int NUM_PAIRS = NUM_OBJ * (NUM_OBJ - 1) / 2;

    logic                         active;
    logic [11:0]                  active_h;
    logic [11:0]                  active_v;
    logic [3:0][7:0]              frame_widths;
    logic [NUM_OBJ-1:0][11:0]     obj_x;
    logic [NUM_OBJ-1:0][11:0]     obj_y;
    logic [NUM_OBJ-1:0]           obj_en;
    logic [NUM_PAIRS-1:0]         coll_pair;
    logic [NUM_OBJ-1:0]           coll_frame;
    logic                         coll_valid;
    logic                         coll_overrun;
    logic [7:0]                   coll_frame_cnt;
    logic                         coll_ack;

    modport master (
        output active, active_h, active_v, frame_widths,
        output obj_x, obj_y, obj_en, coll_ack,
        input  coll_pair, coll_frame, coll_valid, coll_overrun, coll_frame_cnt
    );

    modport slave (
        input  active, active_h, active_v, frame_widths,
        input  obj_x, obj_y, obj_en, coll_ack,
        output coll_pair, coll_frame, coll_valid, coll_overrun, coll_frame_cnt
    );
endinterface

// File: rtl/obj_collision_detect.sv
// obj_collision_detect
//   Pixel-accurate object/object and object/border collision detector.
//   Re-derives per-pixel object coverage from the obj_pkg sprite bitmaps on
//   the same scan the action layer renderer draws, ORs overlaps over a frame
//   and publishes one report per frame through a valid/ack handshake.
//   Ports:
//     vid_clk      video clock (only clock)
//     vid_reset_n  synchronous active-low reset
//     bus          obj_collision_detect_if.slave (pixels, objects, report)
//   Latency: report registers update 2 clocks after the frame-end pixel.

// Sprite table shared with the renderer. Sizes are per object; bitmaps are
// stored [obj][row][col] at a fixed 2**SprBits square.
package obj_pkg;
    localparam int NUM_OBJ = 4;
    localparam int SprBits = 4;
    localparam int SprMax  = 1 << SprBits;

    localparam logic [NUM_OBJ-1:0][11:0] ObjSizeX = {NUM_OBJ{12'd16}};
    localparam logic [NUM_OBJ-1:0][11:0] ObjSizeY = {NUM_OBJ{12'd16}};
    localparam logic [NUM_OBJ-1:0][SprMax-1:0][SprMax-1:0] Obj = '1;
endpackage

package vga_hd_pkg;
    localparam int ActivePels  = 1280;
    localparam int ActiveLines = 720;
endpackage

// Coverage of one object at the current pixel (combinational).
//   active, active_h, active_v  pixel
//   obj_x, obj_y, obj_en        this object's table entry
//   cov                         object covers the pixel with an opaque texel
module obj_cov_lane #(
    parameter int OBJ_IDX = 0
) (
    input  logic        active,
    input  logic [11:0] active_h,
    input  logic [11:0] active_v,
    input  logic [11:0] obj_x,
    input  logic [11:0] obj_y,
    input  logic        obj_en,
    output logic        cov
);
    localparam logic [11:0] SIZE_X = obj_pkg::ObjSizeX[OBJ_IDX];
    localparam logic [11:0] SIZE_Y = obj_pkg::ObjSizeY[OBJ_IDX];

    logic [11:0] rel_x;
    logic [11:0] rel_y;
    logic        in_box;
    logic        opaque;

    // Unsigned wrap: a pixel left of / above the object yields a huge offset
    // that fails the size test, so no signed compare is needed.
    assign rel_x  = active_h - obj_x;
    assign rel_y  = active_v - obj_y;
    assign in_box = (rel_x < SIZE_X) && (rel_y < SIZE_Y);
    // Only meaningful when in_box; low bits suffice since sizes <= SprMax.
    assign opaque = obj_pkg::Obj[OBJ_IDX][rel_y[obj_pkg::SprBits-1:0]][rel_x[obj_pkg::SprBits-1:0]];
    assign cov    = active && obj_en && in_box && opaque;
endmodule

module obj_collision_detect #(
    parameter int NUM_OBJ      = obj_pkg::NUM_OBJ,
    parameter int ACTIVE_PELS  = vga_hd_pkg::ActivePels,
    parameter int ACTIVE_LINES = vga_hd_pkg::ActiveLines
) (
    input  logic                  vid_clk,
    input  logic                  vid_reset_n,
    obj_collision_detect_if.slave bus
);
    localparam int NUM_PAIRS = NUM_OBJ * (NUM_OBJ - 1) / 2;
    localparam int STAGES    = 1;

    localparam logic [11:0] LAST_H = 12'(ACTIVE_PELS - 1);
    localparam logic [11:0] LAST_V = 12'(ACTIVE_LINES - 1);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FULL    = 2'd1;
    localparam logic [1:0] ST_OVERRUN = 2'd2;

    // Lexical pair numbering: (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1).
    function automatic int pair_idx(input int i, input int j);
        return i * (2 * NUM_OBJ - i - 1) / 2 + (j - i - 1);
    endfunction

    // ---------------------------------------------------------------
    // Stage 0: per-pixel coverage, border and frame-end detect
    // ---------------------------------------------------------------
    logic [NUM_OBJ-1:0] cov_d;
    logic               border_d;
    logic               last_d;
    logic [11:0]        right_lim;
    logic [11:0]        bottom_lim;

    for (genvar i = 0; i < NUM_OBJ; i++) begin : g_lane
        obj_cov_lane #(.OBJ_IDX(i)) u_lane (
            .active   (bus.active),
            .active_h (bus.active_h),
            .active_v (bus.active_v),
            .obj_x    (bus.obj_x[i]),
            .obj_y    (bus.obj_y[i]),
            .obj_en   (bus.obj_en[i]),
            .cov      (cov_d[i])
        );
    end

    assign right_lim  = LAST_H - {4'd0, bus.frame_widths[1]};
    assign bottom_lim = LAST_V - {4'd0, bus.frame_widths[3]};

    assign border_d = bus.active && (
                          (bus.active_h < {4'd0, bus.frame_widths[0]}) ||
                          (bus.active_h > right_lim) ||
                          (bus.active_v < {4'd0, bus.frame_widths[2]}) ||
                          (bus.active_v > bottom_lim));

    assign last_d = bus.active && (bus.active_h == LAST_H) && (bus.active_v == LAST_V);

    // ---------------------------------------------------------------
    // Stage 1 registers
    // ---------------------------------------------------------------
    logic [NUM_OBJ-1:0] cov_q;
    logic               border_q;
    logic               last_q;
    logic [STAGES:1]    vld_q;
    logic [STAGES:0]    vld_pipe;

    assign vld_pipe = {vld_q, bus.active};

    // ---------------------------------------------------------------
    // Stage 1 combinational hits
    // ---------------------------------------------------------------
    logic [NUM_PAIRS-1:0] pair_hit;
    logic [NUM_OBJ-1:0]   frame_hit;

    for (genvar i = 0; i < NUM_OBJ; i++) begin : g_pi
        for (genvar j = i + 1; j < NUM_OBJ; j++) begin : g_pj
            localparam int K = pair_idx(i, j);
            assign pair_hit[K] = cov_q[i] & cov_q[j];
        end
    end

    assign frame_hit = cov_q & {NUM_OBJ{border_q}};

    // ---------------------------------------------------------------
    // Stage 2: accumulate, latch and report state
    // ---------------------------------------------------------------
    logic [NUM_PAIRS-1:0] acc_pair;
    logic [NUM_OBJ-1:0]   acc_frame;
    logic [NUM_PAIRS-1:0] pair_rpt;
    logic [NUM_OBJ-1:0]   frame_rpt;
    logic [7:0]           frame_cnt;
    logic [1:0]           state;
    logic [1:0]           state_nxt;

    // coll_ack only matters while a report is held; EMPTY ignores it.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: begin
                if (last_q) state_nxt = ST_FULL;
            end
            ST_FULL: begin
                if (last_q && !bus.coll_ack)      state_nxt = ST_OVERRUN;
                else if (!last_q && bus.coll_ack) state_nxt = ST_EMPTY;
            end
            ST_OVERRUN: begin
                if (bus.coll_ack) state_nxt = last_q ? ST_FULL : ST_EMPTY;
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge vid_clk) begin
        if (!vid_reset_n) begin
            cov_q     <= '0;
            border_q  <= 1'b0;
            last_q    <= 1'b0;
            vld_q     <= '0;
            acc_pair  <= '0;
            acc_frame <= '0;
            pair_rpt  <= '0;
            frame_rpt <= '0;
            frame_cnt <= '0;
            state     <= ST_EMPTY;
        end else begin
            cov_q    <= cov_d;
            border_q <= border_d;
            last_q   <= last_d;
            vld_q    <= vld_pipe[STAGES-1:0];
            state    <= state_nxt;
            if (last_q) begin
                // Report includes the frame-end pixel itself.
                pair_rpt  <= acc_pair | pair_hit;
                frame_rpt <= acc_frame | frame_hit;
                acc_pair  <= '0;
                acc_frame <= '0;
                frame_cnt <= frame_cnt + 8'd1;
            end else if (vld_pipe[STAGES]) begin
                acc_pair  <= acc_pair | pair_hit;
                acc_frame <= acc_frame | frame_hit;
            end
        end
    end

    assign bus.coll_pair      = pair_rpt;
    assign bus.coll_frame     = frame_rpt;
    assign bus.coll_frame_cnt = frame_cnt;
    assign bus.coll_valid     = (state != ST_EMPTY);
    assign bus.coll_overrun   = (state == ST_OVERRUN);
endmodule

// File: tb/tb_obj_collision_detect.sv
module tb_obj_collision_detect;
    localparam int N     = 4;
    localparam int NP    = N * (N - 1) / 2;
    localparam int PELS  = 1280;
    localparam int LINES = 720;

    typedef struct {
        logic [NP-1:0] pair;
        logic [N-1:0]  frame;
        logic [7:0]    cnt;
        int            cyc;
    } exp_t;

    logic vid_clk;
    logic vid_reset_n;

    obj_collision_detect_if #(.NUM_OBJ(N)) bus ();

    obj_collision_detect #(
        .NUM_OBJ      (N),
        .ACTIVE_PELS  (PELS),
        .ACTIVE_LINES (LINES)
    ) dut (
        .vid_clk     (vid_clk),
        .vid_reset_n (vid_reset_n),
        .bus         (bus)
    );

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc   = 0;
    exp_t          sb[$];
    logic [NP-1:0] m_pair;
    logic [N-1:0]  m_frame;
    logic [7:0]    m_cnt;
    logic [7:0]    mon_cnt;

    initial begin
        vid_clk = 1'b0;
        forever #5 vid_clk = ~vid_clk;
    end

    initial forever begin
        @(posedge vid_clk);
        cyc++;
    end

    // Scoreboard: a report is recognised by coll_frame_cnt moving.
    initial begin
        exp_t e;
        forever begin
            @(negedge vid_clk);
            if (vid_reset_n !== 1'b1) begin
                mon_cnt = bus.coll_frame_cnt;
            end else if (bus.coll_frame_cnt !== mon_cnt) begin
                mon_cnt = bus.coll_frame_cnt;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL report_unexpected: cnt=%0d appeared, required no report", bus.coll_frame_cnt);
                end else begin
                    e = sb.pop_front();
                    if (bus.coll_pair !== e.pair) begin
                        n_bad++;
                        $display("FAIL sb_pair: got %b required %b", bus.coll_pair, e.pair);
                    end
                    n_cmp++;
                    if (bus.coll_frame !== e.frame) begin
                        n_bad++;
                        $display("FAIL sb_frame: got %b required %b", bus.coll_frame, e.frame);
                    end
                    n_cmp++;
                    if (bus.coll_frame_cnt !== e.cnt) begin
                        n_bad++;
                        $display("FAIL sb_cnt: got %0d required %0d", bus.coll_frame_cnt, e.cnt);
                    end
                    n_cmp++;
                    if (cyc - e.cyc !== 2) begin
                        n_bad++;
                        $display("FAIL sb_latency: got %0d clocks required 2", cyc - e.cyc);
                    end
                end
            end
        end
    end

    // Independent reference: plain integer box test, no wrap arithmetic.
    task automatic model_pixel(input int h, input int v);
        logic [N-1:0] c;
        bit           b;
        int           k;
        exp_t         e;
        for (int i = 0; i < N; i++) begin
            c[i] = bus.obj_en[i] &&
                   h >= int'(bus.obj_x[i]) && h < int'(bus.obj_x[i]) + 16 &&
                   v >= int'(bus.obj_y[i]) && v < int'(bus.obj_y[i]) + 16;
        end
        b = (h < int'(bus.frame_widths[0])) || (h > PELS - 1 - int'(bus.frame_widths[1])) ||
            (v < int'(bus.frame_widths[2])) || (v > LINES - 1 - int'(bus.frame_widths[3]));
        k = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                if (c[i] && c[j]) m_pair[k] = 1'b1;
                k++;
            end
        end
        if (b) m_frame = m_frame | c;
        if (h == PELS - 1 && v == LINES - 1) begin
            m_cnt   = m_cnt + 8'd1;
            e.pair  = m_pair;
            e.frame = m_frame;
            e.cnt   = m_cnt;
            e.cyc   = cyc;
            sb.push_back(e);
            m_pair  = '0;
            m_frame = '0;
        end
    endtask

    task automatic drive_pix(input int h, input int v, input bit act, input bit ack);
        @(posedge vid_clk);
        #1;
        bus.active   = act;
        bus.active_h = 12'(h);
        bus.active_v = 12'(v);
        bus.coll_ack = ack;
        if (act) model_pixel(h, v);
    endtask

    // Inactive cycles park on coordinates where objects overlap.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_pix(105, 105, 1'b0, 1'b0);
    endtask

    task automatic scan_rect(input int h0, input int v0, input int w, input int hh);
        for (int v = v0; v < v0 + hh; v++)
            for (int h = h0; h < h0 + w; h++)
                drive_pix(h, v, 1'b1, 1'b0);
    endtask

    task automatic end_frame();
        drive_pix(PELS - 1, LINES - 1, 1'b1, 1'b0);
        idle(2);
        @(negedge vid_clk);
    endtask

    task automatic set_obj(input int i, input int x, input int y, input bit en);
        bus.obj_x[i]  = 12'(x);
        bus.obj_y[i]  = 12'(y);
        bus.obj_en[i] = en;
    endtask

    task automatic do_reset();
        @(posedge vid_clk);
        #1;
        vid_reset_n  = 1'b0;
        bus.active   = 1'b0;
        bus.coll_ack = 1'b0;
        repeat (2) @(posedge vid_clk);
        #1;
        vid_reset_n = 1'b1;
        m_pair  = '0;
        m_frame = '0;
        m_cnt   = '0;
        sb.delete();
    endtask

    task automatic do_ack();
        drive_pix(105, 105, 1'b0, 1'b1);
        drive_pix(105, 105, 1'b0, 1'b0);
        @(negedge vid_clk);
        n_cmp++;
        if (bus.coll_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_valid: got %b required 0", bus.coll_valid);
        end
        n_cmp++;
        if (bus.coll_overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_overrun: got %b required 0", bus.coll_overrun);
        end
    endtask

    task automatic test_reset();
        vid_reset_n = 1'b0;
        repeat (3) @(posedge vid_clk);
        @(negedge vid_clk);
        n_cmp++;
        if (bus.coll_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b required 0", bus.coll_valid); end
        n_cmp++;
        if (bus.coll_overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun: got %b required 0", bus.coll_overrun); end
        n_cmp++;
        if (bus.coll_pair !== '0) begin n_bad++; $display("FAIL rst_pair: got %b required 0", bus.coll_pair); end
        n_cmp++;
        if (bus.coll_frame !== '0) begin n_bad++; $display("FAIL rst_frame: got %b required 0", bus.coll_frame); end
        n_cmp++;
        if (bus.coll_frame_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d required 0", bus.coll_frame_cnt); end
        #1;
        vid_reset_n = 1'b1;
    endtask

    task automatic test_overlap();
        set_obj(0, 100, 100, 1'b1);
        set_obj(1, 110, 105, 1'b1);
        set_obj(2, 500, 500, 1'b1);
        set_obj(3, 600, 500, 1'b1);
        bus.frame_widths = '0;
        scan_rect(96, 96, 36, 28);
        idle(3);
        drive_pix(PELS - 1, LINES - 1, 1'b1, 1'b0);
        drive_pix(105, 105, 1'b0, 1'b0);
        @(negedge vid_clk);
        n_cmp++;
        if (bus.coll_valid !== 1'b0) begin n_bad++; $display("FAIL ovl_valid_early: got %b required 0", bus.coll_valid); end
        drive_pix(105, 105, 1'b0, 1'b0);
        @(negedge vid_clk);
        n_cmp++;
        if (bus.coll_valid !== 1'b1) begin n_bad++; $display("FAIL ovl_valid_at2: got %b required 1", bus.coll_valid); end
        n_cmp++;
        if (bus.coll_pair !== 6'b000001) begin n_bad++; $display("FAIL ovl_pair: got %b required 000001", bus.coll_pair); end
        n_cmp++;
        if (bus.coll_frame !== 4'b0000) begin n_bad++; $display("FAIL ovl_frame: got %b required 0000", bus.coll_frame); end
        do_ack();
    endtask

    task automatic test_touching();
        set_obj(1, 116, 100, 1'b1);
        scan_rect(96, 96, 36, 28);
        end_frame();
        n_cmp++;
        if (bus.coll_pair !== 6'b0) begin n_bad++; $display("FAIL touch_pair: got %b required 000000", bus.coll_pair); end
        do_ack();
        set_obj(1, 110, 105, 1'b0);
        scan_rect(96, 96, 36, 28);
        end_frame();
        n_cmp++;
        if (bus.coll_pair !== 6'b0) begin n_bad++; $display("FAIL disabled_pair: got %b required 000000", bus.coll_pair); end
        do_ack();
    endtask

    task automatic test_border();
        set_obj(1, 200, 100, 1'b1);
        set_obj(2, 0, 300, 1'b1);
        bus.frame_widths = {8'd0, 8'd0, 8'd0, 8'd8};
        scan_rect(0, 296, 24, 24);
        end_frame();
        n_cmp++;
        if (bus.coll_frame !== 4'b0100) begin n_bad++; $display("FAIL border_hit: got %b required 0100", bus.coll_frame); end
        do_ack();
        set_obj(2, 8, 300, 1'b1);
        scan_rect(0, 296, 30, 24);
        end_frame();
        n_cmp++;
        if (bus.coll_frame !== 4'b0000) begin n_bad++; $display("FAIL border_edge: got %b required 0000", bus.coll_frame); end
        do_ack();
    endtask

    task automatic test_wrap();
        set_obj(0, 0, 0, 1'b1);
        set_obj(1, 200, 100, 1'b1);
        set_obj(2, 1278, 718, 1'b1);
        set_obj(3, 1275, 715, 1'b1);
        bus.frame_widths = {8'd1, 8'd1, 8'd1, 8'd1};
        scan_rect(0, 0, 11, 11);
        scan_rect(1270, 710, 10, 9);
        scan_rect(1270, 719, 9, 1);
        end_frame();
        n_cmp++;
        if (bus.coll_pair !== 6'b100000) begin n_bad++; $display("FAIL wrap_pair: got %b required 100000", bus.coll_pair); end
        n_cmp++;
        if (bus.coll_frame !== 4'b1101) begin n_bad++; $display("FAIL wrap_frame: got %b required 1101", bus.coll_frame); end
        do_ack();
    endtask

    task automatic test_handshake();
        do_reset();
        bus.frame_widths = '0;
        set_obj(0, 100, 100, 1'b1);
        set_obj(1, 200, 100, 1'b1);
        set_obj(2, 300, 100, 1'b1);
        set_obj(3, 400, 100, 1'b1);
        do_ack();  // ignored while empty
        for (int f = 1; f <= 3; f++) begin
            scan_rect(96, 98, 8, 4);
            end_frame();
            n_cmp++;
            if (bus.coll_overrun !== (f > 1)) begin
                n_bad++;
                $display("FAIL hs_overrun_f%0d: got %b required %b", f, bus.coll_overrun, f > 1);
            end
        end
        n_cmp++;
        if (bus.coll_frame_cnt !== 8'd3) begin n_bad++; $display("FAIL hs_cnt: got %0d required 3", bus.coll_frame_cnt); end
        do_ack();
        end_frame();
        end_frame();
        // From OVERRUN then from FULL: ack coinciding with the latch edge.
        for (int r = 0; r < 2; r++) begin
            drive_pix(PELS - 1, LINES - 1, 1'b1, 1'b0);
            drive_pix(105, 105, 1'b0, 1'b1);
            drive_pix(105, 105, 1'b0, 1'b0);
            @(negedge vid_clk);
            n_cmp++;
            if (bus.coll_valid !== 1'b1) begin n_bad++; $display("FAIL hs_ackfe_valid%0d: got %b required 1", r, bus.coll_valid); end
            n_cmp++;
            if (bus.coll_overrun !== 1'b0) begin n_bad++; $display("FAIL hs_ackfe_overrun%0d: got %b required 0", r, bus.coll_overrun); end
        end
        do_ack();
    endtask

    task automatic test_reset_mid();
        set_obj(0, 100, 100, 1'b1);
        set_obj(1, 110, 105, 1'b1);
        scan_rect(96, 100, 40, 8);
        scan_rect(0, 360, 20, 1);
        do_reset();
        @(negedge vid_clk);
        n_cmp++;
        if (bus.coll_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b required 0", bus.coll_valid); end
        n_cmp++;
        if (bus.coll_pair !== '0) begin n_bad++; $display("FAIL mid_pair: got %b required 0", bus.coll_pair); end
        n_cmp++;
        if (bus.coll_frame_cnt !== 8'd0) begin n_bad++; $display("FAIL mid_cnt: got %0d required 0", bus.coll_frame_cnt); end
        scan_rect(0, 400, 20, 2);
        end_frame();
        n_cmp++;
        if (bus.coll_pair !== 6'b0) begin n_bad++; $display("FAIL mid_next_pair: got %b required 000000", bus.coll_pair); end
        n_cmp++;
        if (bus.coll_frame_cnt !== 8'd1) begin n_bad++; $display("FAIL mid_next_cnt: got %0d required 1", bus.coll_frame_cnt); end
    endtask

    initial begin
        bus.active       = 1'b0;
        bus.active_h     = '0;
        bus.active_v     = '0;
        bus.frame_widths = '0;
        bus.obj_x        = '0;
        bus.obj_y        = '0;
        bus.obj_en       = '0;
        bus.coll_ack     = 1'b0;
        m_pair  = '0;
        m_frame = '0;
        m_cnt   = '0;
        test_reset();
        test_overlap();
        test_touching();
        test_border();
        test_wrap();
        test_handshake();
        test_reset_mid();
        for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge vid_clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d reports outstanding, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
